prime_pair_search: RTL and testbench
====================================

PRIME_PAIR_SEARCH -- requirements
Module: prime_pair_search

Interface
REQ-001 SHALL have parameter WIDTH, default 8, the candidate, p and q width in bits.
REQ-002 SHALL have parameter CNT_W, default 16, the width of the search-cycle counter.
REQ-003 SHALL have port clk  input  1  the only clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  request to begin a search; sampled only in IDLE.
REQ-006 SHALL have port seed  input  WIDTH  search starting point; sampled together with start.
REQ-007 SHALL have port cand  output  WIDTH  candidate driven to the external combinational prime checker (num).
REQ-008 SHALL have port cand_is_prime  input  1  checker result for cand (AssumePrime), valid in the same cycle.
REQ-009 SHALL have port p  output  WIDTH  first prime found.
REQ-010 SHALL have port q  output  WIDTH  second prime found; always greater than p.
REQ-011 SHALL have port busy  output  1  high while a search state is active.
REQ-012 SHALL have port done  output  1  one-cycle pulse ending every search.
REQ-013 SHALL have port fail  output  1  held high from done until the next accepted start when no pair was found.
REQ-014 SHALL have port cyc_cnt  output  CNT_W  number of candidates evaluated in the last or current search (timing observable).

Function
REQ-015 SHALL implement FSM states IDLE, SEARCH_P, SEARCH_Q, DONE.
REQ-016 In IDLE with start=1 the block SHALL clear p, q, fail and cyc_cnt, load cand = seed|1 (or 3 if seed|1 equals 1), and enter SEARCH_P.
REQ-017 SHALL search odd candidates only; each search-state cycle evaluates exactly one candidate.
REQ-018 In SEARCH_P with cand_is_prime=1 the block SHALL capture p=cand, set cand=cand+2, and enter SEARCH_Q.
REQ-019 In SEARCH_Q with cand_is_prime=1 the block SHALL capture q=cand and enter DONE.
REQ-020 In either search state with cand_is_prime=0 the block SHALL set cand=cand+2 and stay in the same state.
REQ-021 Overflow: if cand equals 2^WIDTH-1 in a search state, and the cycle does not complete the pair, the block SHALL set fail=1 and enter DONE, with no wrap to low values.
REQ-022 SHALL treat a prime found at cand=2^WIDTH-1 in SEARCH_P per REQ-021: p is captured, q stays 0, and fail=1.
REQ-023 SHALL increment cyc_cnt once per search-state cycle and saturate at 2^CNT_W-1.
REQ-024 DONE SHALL last exactly one cycle with done=1 and then return to IDLE.
REQ-025 busy SHALL be 1 exactly in SEARCH_P and SEARCH_Q.
REQ-026 SHALL ignore start outside IDLE, including in DONE.
REQ-027 p, q, fail and cyc_cnt SHALL hold their values in IDLE until the next accepted start.
REQ-028 cand SHALL hold its last value in IDLE and DONE.

Reset
REQ-029 While rst_n=0 the block SHALL hold state IDLE and drive cand, p, q, busy, done, fail and cyc_cnt to 0, regardless of clk.
REQ-030 A reset asserted mid-search SHALL abort the search immediately, with no done pulse, and the next start after release SHALL begin a fresh search.

Verification
REQ-031 seed=7 with a true checker -> p=7, then 9 rejected, q=11; done one cycle after 11 is evaluated; cyc_cnt=3; fail=0.
REQ-032 seed=0 -> cand starts at 3; p=3, q=5; cyc_cnt=2; fail=0.
REQ-033 seed=250 -> p=251, 253 and 255 rejected; done with fail=1, q=0, cyc_cnt=3; no wrap to 1.
REQ-034 start pulsed with seed=100 during a busy seed=14 search -> result still p=17, q=19, cyc_cnt=3; the second start is ignored.
REQ-035 rst_n pulsed low during SEARCH_Q -> all outputs 0 at once, no done pulse; a restart with seed=7 reproduces REQ-031.
REQ-036 Stuck checker (cand_is_prime=0) with seed=0 -> 127 candidates (3 through 255) evaluated, cyc_cnt=127, fail=1, busy drops in the DONE cycle.

Source files
------------

// File: rtl/prime_pair_search.sv
// Searches odd candidates upward from a seed for two consecutive primes p < q,
// using an external combinational prime checker that evaluates cand each cycle.
module prime_pair_search #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] seed,
  output logic [WIDTH-1:0] cand,
  input  logic             cand_is_prime,
  output logic [WIDTH-1:0] p,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic             fail,
  output logic [CNT_W-1:0] cyc_cnt
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEARCH_P = 2'd1,
    SEARCH_Q = 2'd2,
    DONE     = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0] CAND_ONE   = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] CAND_TWO   = {{(WIDTH-2){1'b0}}, 2'b10};
  localparam logic [WIDTH-1:0] CAND_THREE = {{(WIDTH-2){1'b0}}, 2'b11};
  localparam logic [WIDTH-1:0] CAND_MAX   = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] CAND_ZERO  = {WIDTH{1'b0}};
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};

  state_t           state_r, state_s;
  logic [WIDTH-1:0] cand_r, cand_s, p_r, p_s, q_r, q_s, seed_odd_s;
  logic             fail_r, fail_s, busy_r, done_r, at_max_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;

  // Next-state and datapath update for the search FSM.
  always_comb begin
    state_s    = state_r;
    cand_s     = cand_r;
    p_s        = p_r;
    q_s        = q_r;
    fail_s     = fail_r;
    cnt_s      = cnt_r;
    seed_odd_s = seed | CAND_ONE;
    at_max_s   = (cand_r == CAND_MAX);
    case (state_r)
      IDLE: begin
        if (start) begin
          p_s     = CAND_ZERO;
          q_s     = CAND_ZERO;
          fail_s  = 1'b0;
          cnt_s   = CNT_ZERO;
          cand_s  = (seed_odd_s == CAND_ONE) ? CAND_THREE : seed_odd_s;
          state_s = SEARCH_P;
        end else begin
          state_s = IDLE;
        end
      end
      SEARCH_P: begin
        if (cand_is_prime) begin
          p_s = cand_r;
        end else begin
          p_s = p_r;
        end
        // The top candidate never advances: cand must not wrap to low values.
        if (at_max_s) begin
          fail_s  = 1'b1;
          state_s = DONE;
        end else if (cand_is_prime) begin
          cand_s  = cand_r + CAND_TWO;
          state_s = SEARCH_Q;
        end else begin
          cand_s  = cand_r + CAND_TWO;
          state_s = SEARCH_P;
        end
      end
      SEARCH_Q: begin
        if (cand_is_prime) begin
          q_s     = cand_r;
          state_s = DONE;
        end else if (at_max_s) begin
          fail_s  = 1'b1;
          state_s = DONE;
        end else begin
          cand_s  = cand_r + CAND_TWO;
          state_s = SEARCH_Q;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    if ((state_r == SEARCH_P || state_r == SEARCH_Q) && cnt_r != CNT_MAX) begin
      cnt_s = cnt_r + CNT_ONE;
    end else begin
      cnt_s = cnt_s;
    end
  end

  // State and result registers; busy/done are registered decodes of the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      cand_r  <= CAND_ZERO;
      p_r     <= CAND_ZERO;
      q_r     <= CAND_ZERO;
      fail_r  <= 1'b0;
      cnt_r   <= CNT_ZERO;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cand_r  <= cand_s;
      p_r     <= p_s;
      q_r     <= q_s;
      fail_r  <= fail_s;
      cnt_r   <= cnt_s;
      busy_r  <= (state_s == SEARCH_P) || (state_s == SEARCH_Q);
      done_r  <= (state_s == DONE);
    end
  end

  assign cand    = cand_r;
  assign p       = p_r;
  assign q       = q_r;
  assign fail    = fail_r;
  assign cyc_cnt = cnt_r;
  assign busy    = busy_r;
  assign done    = done_r;

endmodule

// File: tb/tb_prime_pair_search.sv
// Self-checking bench for prime_pair_search: a loop-based reference model of the
// search plus fixed scenarios and randomized seeds.
module tb_prime_pair_search;
  localparam int W = 8;
  localparam int CW = 16;
  localparam int MAXC = (1 << W) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [W-1:0]  seed = '0;
  logic [W-1:0]  cand, p, q;
  logic          cand_is_prime, busy, done, fail;
  logic [CW-1:0] cyc_cnt;

  bit stuck = 1'b0;
  int tests = 0;
  int fails = 0;
  int acc_seed = 0;

  prime_pair_search #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .seed(seed), .cand(cand),
    .cand_is_prime(cand_is_prime), .p(p), .q(q), .busy(busy), .done(done),
    .fail(fail), .cyc_cnt(cyc_cnt)
  );

  always #5 clk = ~clk;

  function automatic bit is_prime(input int n);
    if (n < 2) return 1'b0;
    for (int d = 2; d * d <= n; d++)
      if (n % d == 0) return 1'b0;
    return 1'b1;
  endfunction

  assign cand_is_prime = stuck ? 1'b0 : is_prime(int'(cand));

  function automatic int first_cand(input int s);
    int c;
    c = s | 1;
    if (c == 1) c = 3;
    return c;
  endfunction

  // Reference: walk odd candidates, count evaluations, stop on pair or at the top value.
  task automatic model(input int s, input bit stk, output int ep, output int eq,
                       output int ef, output int ec);
    int c;
    bit have_p;
    bit pr;
    c = first_cand(s);
    ep = 0; eq = 0; ef = 0; ec = 0; have_p = 0;
    while (1) begin
      ec++;
      pr = !stk && is_prime(c);
      if (pr && have_p) begin eq = c; break; end
      if (pr) ep = c;
      if (c == MAXC) begin ef = 1; break; end
      if (pr) have_p = 1;
      c += 2;
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Per-cycle compare process against the model.
  bit active = 0, prev_busy = 0;
  int k = 0, mp, mq, mf, mc, mfirst;
  always @(negedge clk) begin
    if (!rst_n) begin
      active = 0;
      prev_busy = 0;
    end else begin
      if (busy && !prev_busy) begin
        model(acc_seed, stuck, mp, mq, mf, mc);
        mfirst = first_cand(acc_seed);
        k = 0;
        active = 1;
      end
      if (active) begin
        if (k < mc) begin
          chk("mon_busy", busy, 1);
          chk("mon_cand", cand, mfirst + 2 * k);
          chk("mon_cnt", cyc_cnt, k);
          k++;
        end else begin
          chk("mon_done", done, 1);
          chk("mon_done_busy", busy, 0);
          chk("mon_p", p, mp);
          chk("mon_q", q, mq);
          chk("mon_fail", fail, mf);
          chk("mon_cyc", cyc_cnt, mc);
          active = 0;
        end
      end else begin
        chk("mon_idle_done", done, 0);
        chk("mon_idle_busy", busy, 0);
      end
      prev_busy = busy;
    end
  end

  task automatic do_search(input int s);
    @(negedge clk);
    seed = W'(s);
    start = 1'b1;
    acc_seed = s;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input bit noise);
    bit got;
    got = 0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (done) begin got = 1; break; end
      start = noise && busy && ($urandom_range(0, 7) == 0);
      if (start) seed = W'($urandom_range(0, MAXC));
    end
    start = 1'b0;
    chk("done_timeout", got, 1);
  endtask

  task automatic expect_lit(input string name, input int ep, input int eq, input int ef,
                            input int ec, input int ecand, input bit poke);
    chk({name, "_p"}, p, ep);
    chk({name, "_q"}, q, eq);
    chk({name, "_fail"}, fail, ef);
    chk({name, "_cyc"}, cyc_cnt, ec);
    chk({name, "_cand"}, cand, ecand);
    if (poke) begin
      seed = W'(100);
      start = 1'b1;
    end
    @(negedge clk);
    start = 1'b0;
    chk({name, "_hold_busy"}, busy, 0);
    chk({name, "_hold_p"}, p, ep);
    chk({name, "_hold_q"}, q, eq);
    chk({name, "_hold_fail"}, fail, ef);
    chk({name, "_hold_cyc"}, cyc_cnt, ec);
    chk({name, "_hold_cand"}, cand, ecand);
  endtask

  int ep, eq, ef, ec;
  initial begin
    #3;
    chk("rst_cand", cand, 0); chk("rst_p", p, 0); chk("rst_q", q, 0);
    chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_fail", fail, 0);
    chk("rst_cyc", cyc_cnt, 0);

    model(7, 0, ep, eq, ef, ec);
    chk("model7_p", ep, 7); chk("model7_q", eq, 11); chk("model7_f", ef, 0); chk("model7_c", ec, 3);
    model(250, 0, ep, eq, ef, ec);
    chk("model250_p", ep, 251); chk("model250_q", eq, 0); chk("model250_f", ef, 1); chk("model250_c", ec, 3);
    model(0, 1, ep, eq, ef, ec);
    chk("model_stuck_f", ef, 1); chk("model_stuck_c", ec, 127);

    @(negedge clk);
    rst_n = 1'b1;

    do_search(7);   wait_done(0); expect_lit("seed7", 7, 11, 0, 3, 11, 0);
    do_search(0);   wait_done(0); expect_lit("seed0", 3, 5, 0, 2, 5, 0);
    do_search(250); wait_done(0); expect_lit("seed250", 251, 0, 1, 3, 255, 0);
    do_search(255); wait_done(0); expect_lit("seed255", 0, 0, 1, 1, 255, 0);

    // start pulses mid-search and during DONE must both be ignored
    do_search(14);
    @(negedge clk); seed = W'(100); start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_done(0); expect_lit("seed14", 17, 19, 0, 3, 19, 1);

    // reset while in SEARCH_Q
    do_search(7);
    @(negedge clk);
    chk("pre_rst_cand", cand, 9);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_cand", cand, 0); chk("mid_rst_p", p, 0); chk("mid_rst_q", q, 0);
    chk("mid_rst_busy", busy, 0); chk("mid_rst_done", done, 0); chk("mid_rst_fail", fail, 0);
    chk("mid_rst_cyc", cyc_cnt, 0);
    repeat (2) begin
      @(negedge clk);
      chk("in_rst_done", done, 0);
    end
    rst_n = 1'b1;
    do_search(7); wait_done(0); expect_lit("restart7", 7, 11, 0, 3, 11, 0);

    stuck = 1'b1;
    do_search(0); wait_done(0); expect_lit("stuck", 0, 0, 1, 127, 255, 0);
    stuck = 1'b0;

    repeat (25) begin
      stuck = ($urandom_range(0, 7) == 0);
      do_search($urandom_range(0, MAXC));
      wait_done(1);
      @(negedge clk);
      stuck = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
